aes_core_arbiter: RTL and testbench
===================================

AES_CORE_ARBITER -- requirements
Module: aes_core_arbiter

Interface
REQ-001 The block SHALL provide parameter TIMEOUT_CYCLES, default 16, meaning max cycles waited for core_done after core_start.
REQ-002 The block SHALL provide parameter NUM_REQ, fixed 2, meaning number of requester ports.
REQ-003 The block SHALL use one clock, clk, and reset, which is asynchronous and active-low.
REQ-004 The block SHALL provide these ports:
- clk  in  1  rising-edge clock
- reset  in  1  async active-low reset
- req_valid  in  2  per-requester block request
- req_ready  out  2  per-requester accept
- req_block  in  2x128  per-requester plaintext
- req_key  in  2x128  per-requester cipher key
- core_start  out  1  one-cycle launch pulse to AES core
- core_block  out  128  plaintext to core
- core_key  out  128  key to core
- core_done  in  1  core result-valid pulse
- core_result  in  128  core ciphertext
- resp_valid  out  1  response available
- resp_ready  in  1  response consumer accept
- resp_id  out  1  index of requester served
- resp_block  out  128  ciphertext, or zero on error
- resp_err  out  1  timeout flag for this response
- busy  out  1  high in any state except IDLE

Function
REQ-005 The block SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-006 In IDLE the block SHALL drive req_ready high combinationally for exactly one requester: the pointer requester if its req_valid is high, else the other requester if its req_valid is high, else none.
REQ-007 On req_valid&req_ready the block SHALL latch req_block, req_key and the index, then enter ISSUE.
REQ-008 In ISSUE the block SHALL assert core_start for exactly one cycle, with core_block/core_key held at latched values from ISSUE until RESP exits, then enter WAIT.
REQ-009 In WAIT a timer cleared on WAIT entry SHALL increment each cycle; on core_done the block SHALL latch core_result, set resp_err=0 and enter RESP.
REQ-010 If the timer reaches TIMEOUT_CYCLES-1 without core_done, the block SHALL enter RESP with resp_block=0 and resp_err=1; core_done in that same cycle SHALL take precedence (success).
REQ-011 The block SHALL ignore core_done in IDLE, ISSUE and RESP.
REQ-012 In RESP the block SHALL hold resp_valid, resp_id, resp_block and resp_err stable until resp_ready; on resp_valid&resp_ready it SHALL set the pointer to the requester not served and return to IDLE.
REQ-013 Latency: acceptance at cycle N SHALL give core_start at N+1 and resp_valid at the cycle after core_done.
REQ-014 The block SHALL drive req_ready to 0 in every state except IDLE; requests are not queued.
REQ-015 Requester input changes after acceptance SHALL NOT affect the in-flight operation.

Reset
REQ-016 While reset is low, the block SHALL force: state IDLE; pointer 0; timer 0; core_start, resp_valid, resp_err, resp_id and busy 0; core_block, core_key and resp_block 0.
REQ-017 Reset asserted mid-operation SHALL abandon the operation with no response; the first post-reset acceptance SHALL follow REQ-006 with pointer 0.

Structure
REQ-018 A shared package aes_ctrl_pkg SHALL hold the FSM state enum, BLOCK_W=128 and KEY_W=128.
REQ-019 Requester selection SHALL be a sub-module, aes_rr_pick: inputs valid[1:0] and pointer; outputs one-hot grant.

Verification
REQ-020 With only req_valid[0], block 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, and core model done after 11 cycles, the bench SHALL see core_start at N+1 and resp_block 69c4e0d86a7b0430d8cdb78070b4c55a, resp_id 0, resp_err 0.
REQ-021 With both req_valid held high for 4 operations, the bench SHALL see resp_id sequence 0,1,0,1.
REQ-022 With core model never asserting core_done and TIMEOUT_CYCLES=16, the bench SHALL see resp_valid 16 cycles after WAIT entry, with resp_err 1 and resp_block 0.
REQ-023 With resp_ready held low 5 cycles in RESP, the bench SHALL see resp_* stable, req_ready 00 and busy 1 throughout.
REQ-024 With reset pulsed low during WAIT, the bench SHALL see all outputs 0 with no response; the next req_valid=11 SHALL be granted to requester 0.
REQ-025 With a spurious core_done in IDLE, the bench SHALL see no state change and no resp_valid.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// rtl/aes_ctrl_pkg.sv - shared widths and FSM state type for the AES core arbiter
package aes_ctrl_pkg;

    localparam int BLOCK_W = 128;
    localparam int KEY_W   = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/aes_core_arbiter_if.sv
// rtl/aes_core_arbiter_if.sv - requester, AES core and response bundle for the arbiter
interface aes_core_arbiter_if;
    import aes_ctrl_pkg::*;

    logic [1:0]              req_valid;
    logic [1:0]              req_ready;
    logic [1:0][BLOCK_W-1:0] req_block;
    logic [1:0][KEY_W-1:0]   req_key;

    logic                    core_start;
    logic [BLOCK_W-1:0]      core_block;
    logic [KEY_W-1:0]        core_key;
    logic                    core_done;
    logic [BLOCK_W-1:0]      core_result;

    logic                    resp_valid;
    logic                    resp_ready;
    logic                    resp_id;
    logic [BLOCK_W-1:0]      resp_block;
    logic                    resp_err;
    logic                    busy;

    modport slave (
        input  req_valid, req_block, req_key, core_done, core_result, resp_ready,
        output req_ready, core_start, core_block, core_key,
               resp_valid, resp_id, resp_block, resp_err, busy
    );

    modport master (
        output req_valid, req_block, req_key, core_done, core_result, resp_ready,
        input  req_ready, core_start, core_block, core_key,
               resp_valid, resp_id, resp_block, resp_err, busy
    );

endinterface

// File: rtl/aes_rr_pick.sv
// rtl/aes_rr_pick.sv - two-way round-robin pick: pointer requester first, else the other
module aes_rr_pick (
    input  logic [1:0] valid,
    input  logic       pointer,
    output logic [1:0] grant
);

    // one-hot grant, favouring the requester the pointer names
    always_comb begin
        grant = 2'b00;
        if (valid[pointer]) begin
            grant[pointer] = 1'b1;
        end else if (valid[~pointer]) begin
            grant[~pointer] = 1'b1;
        end
    end

endmodule

// File: rtl/aes_core_arbiter.sv
// rtl/aes_core_arbiter.sv - shares one AES core between two requesters with timeout
module aes_core_arbiter
    import aes_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int NUM_REQ        = 2
) (
    input  logic              clk,
    input  logic              reset,
    aes_core_arbiter_if.slave bus
);

    // one spare bit so the timer can step past TIMEOUT_CYCLES-1 without wrapping
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic [NUM_REQ-1:0] grant;
    logic               pointer;
    logic               sel_idx;
    logic [BLOCK_W-1:0] blk_q;
    logic [KEY_W-1:0]   key_q;
    logic [TMR_W-1:0]   timer;
    logic [BLOCK_W-1:0] res_q;
    logic               err_q;
    logic               accept;
    logic               timeout_hit;
    logic               resp_fire;

    aes_rr_pick u_pick (
        .valid   (bus.req_valid),
        .pointer (pointer),
        .grant   (grant)
    );

    assign accept      = (state == IDLE) && (|grant);
    assign timeout_hit = (timer == TMR_W'(TIMEOUT_CYCLES - 1));
    assign resp_fire   = (state == RESP) && bus.resp_ready;

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state, ready and launch pulse; core_done outside WAIT is simply not looked at
    always_comb begin
        state_nxt      = state;
        bus.req_ready  = 2'b00;
        bus.core_start = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = grant;
                if (|grant) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                bus.core_start = 1'b1;
                state_nxt      = WAIT;
            end
            WAIT: begin
                if (bus.core_done || timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // capture the granted requester's operands so later input changes cannot leak in
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blk_q   <= '0;
            key_q   <= '0;
            sel_idx <= 1'b0;
        end else if (accept) begin
            blk_q   <= bus.req_block[grant[1]];
            key_q   <= bus.req_key[grant[1]];
            sel_idx <= grant[1];
        end
    end

    // wait timer: cleared while issuing, counts every WAIT cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (state == ISSUE) begin
            timer <= '0;
        end else if (state == WAIT) begin
            timer <= timer + 1'b1;
        end
    end

    // result capture; a done arriving on the last timer cycle still counts as success
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_q <= '0;
            err_q <= 1'b0;
        end else if (state == WAIT) begin
            if (bus.core_done) begin
                res_q <= bus.core_result;
                err_q <= 1'b0;
            end else if (timeout_hit) begin
                res_q <= '0;
                err_q <= 1'b1;
            end
        end
    end

    // fairness pointer moves to the requester that was not just served
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pointer <= 1'b0;
        end else if (resp_fire) begin
            pointer <= ~sel_idx;
        end
    end

    assign bus.core_block = blk_q;
    assign bus.core_key   = key_q;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_id    = sel_idx;
    assign bus.resp_block = res_q;
    assign bus.resp_err   = err_q;
    assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_aes_core_arbiter.sv
// tb/tb_aes_core_arbiter.sv - self-checking bench for aes_core_arbiter
module tb_aes_core_arbiter;
    import aes_ctrl_pkg::*;

    localparam int           TMO     = 16;
    localparam logic [127:0] AES_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] AES_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] AES_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct {
        logic [1:0] valid;
        int         dly;
        int         hold;
        bit         use_aes;
        int         exp_id;
        logic       exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    aes_core_arbiter_if aif();

    aes_core_arbiter #(.TIMEOUT_CYCLES(TMO), .NUM_REQ(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (aif)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // stand-in AES core: the known test vector, otherwise an arbitrary mixing of block and key
    function automatic logic [127:0] core_fn(input logic [127:0] b, input logic [127:0] k);
        if (b == AES_PT && k == AES_KEY) return AES_CT;
        return {b[63:0], b[127:64]} ^ k ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"},  128'(aif.req_ready),  128'(0));
        check({tag, "_core_start"}, 128'(aif.core_start), 128'(0));
        check({tag, "_core_block"}, aif.core_block,       128'(0));
        check({tag, "_core_key"},   aif.core_key,         128'(0));
        check({tag, "_resp_valid"}, 128'(aif.resp_valid), 128'(0));
        check({tag, "_resp_id"},    128'(aif.resp_id),    128'(0));
        check({tag, "_resp_block"}, aif.resp_block,       128'(0));
        check({tag, "_resp_err"},   128'(aif.resp_err),   128'(0));
        check({tag, "_busy"},       128'(aif.busy),       128'(0));
    endtask

    // one complete transaction; starts and ends just after a falling edge with the DUT idle.
    // dly = cycles after the core_start cycle at which core_done pulses (0 = never)
    task automatic run_op(input logic [1:0] v, input int dly, input int hold,
                          input logic [1:0][127:0] blks, input logic [1:0][127:0] keys,
                          input int exp_id, input logic exp_err);
        int           k;
        int           exp_k;
        int           n_start;
        bit           got;
        logic [127:0] exp_blk;
        logic [127:0] hb;
        logic         hid;
        logic         herr;
        aif.req_valid  = v;
        aif.req_block  = blks;
        aif.req_key    = keys;
        aif.resp_ready = 1'b0;
        #1;
        check("grant", 128'(aif.req_ready), 128'(2'b01 << exp_id));
        @(negedge clk);
        aif.req_valid = 2'b00;
        aif.req_block = {rnd128(), rnd128()};
        aif.req_key   = {rnd128(), rnd128()};
        #1;
        check("core_start",      128'(aif.core_start), 128'(1));
        check("core_block",      aif.core_block,       blks[exp_id]);
        check("core_key",        aif.core_key,         keys[exp_id]);
        check("req_ready_issue", 128'(aif.req_ready),  128'(0));
        n_start = 0;
        got     = 1'b0;
        k       = 0;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            aif.core_done   = (dly != 0 && k == dly);
            aif.core_result = core_fn(blks[exp_id], keys[exp_id]);
            #1;
            if (aif.core_start) n_start++;
            if (aif.resp_valid) got = 1'b1;
        end
        exp_k   = (dly >= 1 && dly <= TMO) ? dly + 1 : TMO + 1;
        exp_blk = exp_err ? 128'(0) : core_fn(blks[exp_id], keys[exp_id]);
        check("resp_latency",   128'(k),            128'(exp_k));
        check("start_one_shot", 128'(n_start),      128'(0));
        check("resp_id",        128'(aif.resp_id),  128'(exp_id));
        check("resp_err",       128'(aif.resp_err), 128'(exp_err));
        check("resp_block",     aif.resp_block,     exp_blk);
        hb   = aif.resp_block;
        hid  = aif.resp_id;
        herr = aif.resp_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            aif.core_done = 1'b0;
            aif.req_valid = 2'b11;
            #1;
            check("hold_valid",     128'(aif.resp_valid), 128'(1));
            check("hold_id",        128'(aif.resp_id),    128'(hid));
            check("hold_err",       128'(aif.resp_err),   128'(herr));
            check("hold_block",     aif.resp_block,       hb);
            check("hold_req_ready", 128'(aif.req_ready),  128'(0));
            check("hold_busy",      128'(aif.busy),       128'(1));
        end
        aif.req_valid  = 2'b00;
        aif.resp_ready = 1'b1;
        @(negedge clk);
        aif.core_done  = 1'b0;
        aif.resp_ready = 1'b0;
        #1;
        check("idle_busy",       128'(aif.busy),       128'(0));
        check("idle_resp_valid", 128'(aif.resp_valid), 128'(0));
    endtask

    initial begin
        vec_t              tbl[11];
        logic [1:0][127:0] b;
        logic [1:0][127:0] kk;
        int                ptr;
        int                v;
        int                d;
        int                h;
        int                id;
        logic              e;

        reset           = 1'b0;
        aif.req_valid   = 2'b00;
        aif.req_block   = '0;
        aif.req_key     = '0;
        aif.core_done   = 1'b0;
        aif.core_result = '0;
        aif.resp_ready  = 1'b0;

        //            valid  dly hold aes id err
        tbl[0]  = '{2'b11,  5, 0, 1'b0, 0, 1'b0};
        tbl[1]  = '{2'b11,  2, 1, 1'b0, 1, 1'b0};
        tbl[2]  = '{2'b11,  7, 0, 1'b0, 0, 1'b0};
        tbl[3]  = '{2'b11,  1, 0, 1'b0, 1, 1'b0};
        tbl[4]  = '{2'b01, 11, 0, 1'b1, 0, 1'b0};
        tbl[5]  = '{2'b11,  3, 5, 1'b0, 1, 1'b0};
        tbl[6]  = '{2'b11, 16, 0, 1'b0, 0, 1'b0};
        tbl[7]  = '{2'b10,  0, 2, 1'b0, 1, 1'b1};
        tbl[8]  = '{2'b11, 17, 0, 1'b0, 0, 1'b1};
        tbl[9]  = '{2'b01,  4, 0, 1'b0, 0, 1'b0};
        tbl[10] = '{2'b10,  6, 0, 1'b0, 1, 1'b0};

        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;

        // core_done while idle must be ignored
        aif.core_done   = 1'b1;
        aif.core_result = rnd128();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check("spurious_resp_valid", 128'(aif.resp_valid), 128'(0));
            check("spurious_busy",       128'(aif.busy),       128'(0));
        end
        aif.core_done = 1'b0;
        @(negedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            b  = {rnd128(), rnd128()};
            kk = {rnd128(), rnd128()};
            if (tbl[i].use_aes) begin
                b[0]  = AES_PT;
                kk[0] = AES_KEY;
            end
            run_op(tbl[i].valid, tbl[i].dly, tbl[i].hold, b, kk, tbl[i].exp_id, tbl[i].exp_err);
        end

        // move pointer to 1, then reset in WAIT and expect requester 0 to win afterwards
        b  = {rnd128(), rnd128()};
        kk = {rnd128(), rnd128()};
        run_op(2'b01, 3, 0, b, kk, 0, 1'b0);
        aif.req_valid = 2'b11;
        #1;
        check("pre_reset_grant", 128'(aif.req_ready), 128'(2'b10));
        @(negedge clk);
        aif.req_valid = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        check("wait_busy", 128'(aif.busy), 128'(1));
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("post_reset_resp_valid", 128'(aif.resp_valid), 128'(0));
            check("post_reset_busy",       128'(aif.busy),       128'(0));
        end
        b  = {rnd128(), rnd128()};
        kk = {rnd128(), rnd128()};
        run_op(2'b11, 4, 0, b, kk, 0, 1'b0);

        // randomized traffic against a round-robin/timeout reference model
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        ptr = 0;
        for (int i = 0; i < 30; i++) begin
            v  = $urandom_range(1, 3);
            d  = $urandom_range(0, 18);
            h  = $urandom_range(0, 3);
            b  = {rnd128(), rnd128()};
            kk = {rnd128(), rnd128()};
            id = (v == 3) ? ptr : ((v == 1) ? 0 : 1);
            e  = (d == 0 || d > TMO);
            run_op(2'(v), d, h, b, kk, id, e);
            ptr = 1 - id;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
